// File: rtl/add_seq_n.sv
// Multi-cycle adder: adds two WIDTH-bit operands CHUNK bits per clock, with carry-in,
// carry-out and signed overflow. Optional subtract mode is enabled by ADD_SEQ_SUB_EN.
module add_seq_n #(
    parameter int WIDTH = 16,  // must be >= 2
    parameter int CHUNK = 4    // must divide WIDTH exactly
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state_o
);
    // Handshakes: a transfer occurs on a rising edge where valid and ready are both 1;
    // the producer holds in_valid/operands until in_ready, and the result is held until out_ready.

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             sub_eff;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK:0]   chunk_res;
    logic [WIDTH-1:0] acc_new;

`ifdef ADD_SEQ_SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    // One CHUNK-bit ripple per cycle is the only arithmetic path.
    always_comb begin
        chunk_a   = a_q[idx_q*CHUNK +: CHUNK];
        chunk_b   = b_q[idx_q*CHUNK +: CHUNK];
        chunk_res = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
        acc_new   = acc_q;
        acc_new[idx_q*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + 1, so B is stored inverted and the carry seeded to 1.
                    a_d     = a;
                    b_d     = sub_eff ? ~b : b;
                    carry_d = sub_eff ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d   = acc_new;
                carry_d = chunk_res[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    sum_d   = acc_new;
                    cout_d  = chunk_res[CHUNK];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_new[WIDTH-1] != a_q[WIDTH-1]);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_add_seq_n.sv
// Directed bench for add_seq_n: default 4-bit chunking plus a single-chunk instance.
module tb_add_seq_n;
    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        cin, cout, ovf, sub;
    logic [1:0]  dbg_state;

    logic        iv1, ir1, ov1, or1;
    logic [15:0] a1, b1, sum1;
    logic        cin1, cout1, ovf1;
    logic [1:0]  dbg1;

    int err_cnt = 0;
    int chk_cnt = 0;

    add_seq_n #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef ADD_SEQ_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .dbg_state_o(dbg_state)
    );

    add_seq_n #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .cin(cin1),
`ifdef ADD_SEQ_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(ov1), .out_ready(or1),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .dbg_state_o(dbg1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one operation and leave the bench 1 time unit after the accept edge.
    // Operand inputs are scrambled right after acceptance; the result must not change.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                            input logic sv);
        int waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("ready_before_accept", {31'd0, in_ready}, 32'd1);
        a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~av; b = ~bv; cin = ~cv; sub = ~sv;
    endtask

    task automatic wait_done(input int exp_lat);
        int lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        check("latency", lat, exp_lat);
    endtask

    task automatic expect_result(input string tag, input logic [15:0] s, input logic c,
                                 input logic o);
        check({tag, "_sum"}, {16'd0, sum}, {16'd0, s});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, c});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, o});
    endtask

    task automatic finish_op;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);
        check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int ov_seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        expect_result("rst", 16'h0000, 1'b0, 1'b0);

        // full carry ripple into cout
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check("busy_in_ready", {31'd0, in_ready}, 32'd0);
        wait_done(4);
        expect_result("ffff_p1", 16'h0000, 1'b1, 1'b0);
        finish_op();

        // positive overflow
        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_done(4);
        expect_result("7fff_p1", 16'h8000, 1'b0, 1'b1);
        finish_op();

        // negative overflow with carry out
        start_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        wait_done(4);
        expect_result("8000_p8000", 16'h0000, 1'b1, 1'b1);
        finish_op();

        // carry-in propagating through every chunk
        start_op(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        wait_done(4);
        expect_result("aaaa_p5555_c", 16'h0000, 1'b1, 1'b0);
        finish_op();

        // carry-in, backpressure hold, and ignored in_valid while DONE
        start_op(16'h1234, 16'h0FF0, 1'b1, 1'b0);
        wait_done(4);
        expect_result("1234_p0ff0_c", 16'h2225, 1'b0, 1'b0);
        in_valid = 1'b1; a = 16'h1111; b = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_sum", {16'd0, sum}, 32'h2225);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        finish_op();
        check("post_drain_sum", {16'd0, sum}, 32'h2225);

        // reset in the middle of BUSY discards the operation
        start_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_sum", {16'd0, sum}, 32'd0);
        ov_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) ov_seen++;
        end
        check("midrst_no_out_valid", ov_seen, 0);
        start_op(16'h0002, 16'h0003, 1'b0, 1'b0);
        wait_done(4);
        expect_result("2_p3", 16'h0005, 1'b0, 1'b0);
        finish_op();

`ifdef ADD_SEQ_SUB_EN
        // subtract: cin ignored, cout=1 means no borrow
        start_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_done(4);
        expect_result("sub_5_7", 16'hFFFE, 1'b0, 1'b0);
        finish_op();
        start_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_done(4);
        expect_result("sub_8000_1", 16'h7FFF, 1'b1, 1'b1);
        finish_op();
`endif

        // single-chunk instance: one-cycle latency
        check("c16_in_ready", {31'd0, ir1}, 32'd1);
        a1 = 16'h7FFF; b1 = 16'h0001; cin1 = 1'b0; iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0; a1 = 16'h0000; b1 = 16'h0000;
        check("c16_busy_valid", {31'd0, ov1}, 32'd0);
        @(posedge clk); #1;
        check("c16_out_valid", {31'd0, ov1}, 32'd1);
        check("c16_sum", {16'd0, sum1}, 32'h8000);
        check("c16_cout", {31'd0, cout1}, 32'd0);
        check("c16_ovf", {31'd0, ovf1}, 32'd1);
        or1 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0;
        check("c16_drain_ready", {31'd0, ir1}, 32'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
